// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx
// Oversampling UART receiver: centre-samples LSB-first frames on the shared
// baud tick, checks optional parity and stop bit, strobes rx_done per frame.
// Rev     : 1.0  initial release
// ============================================================================
module uart_rx #(
  parameter int BAUD              = 9600,
  parameter int CLK_FREQ          = 50_000_000,
  parameter int OVERSAMPLING_RATE = 16,
  parameter int DATA_WD           = 8,
  parameter int PARITY            = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               rx,
  output logic [DATA_WD-1:0] dout,
  output logic               rx_done,
  output logic               rx_busy,
  output logic               parity_err,
  output logic               frame_err
);

  localparam int c_cnt_w = (OVERSAMPLING_RATE > 1) ? $clog2(OVERSAMPLING_RATE) : 1;
  localparam int c_idx_w = (DATA_WD > 1) ? $clog2(DATA_WD) : 1;
  localparam logic [c_cnt_w-1:0] c_half     = c_cnt_w'(OVERSAMPLING_RATE / 2 - 1);
  localparam logic [c_cnt_w-1:0] c_full     = c_cnt_w'(OVERSAMPLING_RATE - 1);
  localparam logic [c_idx_w-1:0] c_last_bit = c_idx_w'(DATA_WD - 1);
  localparam bit                 c_par_en   = (PARITY == 1) || (PARITY == 2);

  typedef enum logic [5:0] {
    S_IDLE   = 6'b000001,
    S_START  = 6'b000010,
    S_DATA   = 6'b000100,
    S_PARITY = 6'b001000,
    S_STOP   = 6'b010000,
    S_DONE   = 6'b100000
  } state_t;

  state_t               r_state;
  logic [1:0]           r_sync;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_idx_w-1:0]   r_bit_idx;
  logic [DATA_WD-1:0]   r_shift;
  logic                 r_armed;
  logic                 r_perr;
  logic                 w_rxs;
  logic                 w_par_exp;

  assign w_rxs     = r_sync[1];
  assign w_par_exp = (PARITY == 1) ? ^r_shift : ~^r_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], rx};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_armed    <= 1'b0;
      r_perr     <= 1'b0;
      dout       <= '0;
      rx_done    <= 1'b0;
      rx_busy    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (tick) begin
            if (w_rxs) begin
              r_armed <= 1'b1;
            end else if (r_armed) begin
              r_state <= S_START;
              r_cnt   <= '0;
              r_armed <= 1'b0;
              r_perr  <= 1'b0;
              rx_busy <= 1'b1;
            end
          end
        end

        S_START: begin
          if (tick) begin
            if (r_cnt == c_half) begin
              r_cnt <= '0;
              if (!w_rxs) begin
                r_state <= S_DATA;
              end else begin
                r_state <= S_IDLE;
                r_armed <= 1'b1;
                rx_busy <= 1'b0;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end

        S_DATA: begin
          if (tick) begin
            if (r_cnt == c_full) begin
              r_cnt   <= '0;
              // Right shift: the first (LSB) bit ends up at index 0 after DATA_WD shifts.
              r_shift <= DATA_WD'({w_rxs, r_shift} >> 1);
              if (r_bit_idx == c_last_bit) begin
                r_bit_idx <= '0;
                r_state   <= c_par_en ? S_PARITY : S_STOP;
              end else begin
                r_bit_idx <= r_bit_idx + 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end

        S_PARITY: begin
          if (tick) begin
            if (r_cnt == c_full) begin
              r_cnt   <= '0;
              r_perr  <= w_rxs ^ w_par_exp;
              r_state <= S_STOP;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end

        S_STOP: begin
          if (tick) begin
            if (r_cnt == c_full) begin
              r_cnt      <= '0;
              r_state    <= S_DONE;
              dout       <= r_shift;
              parity_err <= r_perr;
              frame_err  <= ~w_rxs;
              rx_done    <= 1'b1;
              // Only a high stop sample re-arms; a break after a bad frame must not retrigger.
              if (w_rxs) begin
                r_armed <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end

        S_DONE: begin
          rx_busy   <= 1'b0;
          r_bit_idx <= '0;
          r_state   <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_rx
// Self-checking bench for uart_rx: three instances (no parity, XOR, XNOR).
// Rev     : 1.0  initial release
// ============================================================================
module tb_uart_rx;

  localparam int OS      = 16;
  localparam int TDIV    = 4;
  localparam int BIT_CLK = OS * TDIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
  logic [7:0] dout0, dout1, dout2;
  logic done0, done1, done2;
  logic busy0, busy1, busy2;
  logic pe0, pe1, pe2;
  logic fe0, fe1, fe2;
  int   tdiv_cnt = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } rec_t;

  rec_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tick     <= (tdiv_cnt == TDIV - 1);
    tdiv_cnt <= (tdiv_cnt == TDIV - 1) ? 0 : tdiv_cnt + 1;
  end

  uart_rx #(.OVERSAMPLING_RATE(OS), .DATA_WD(8), .PARITY(0)) dut0 (
    .clk(clk), .rst(rst), .tick(tick), .rx(rx0), .dout(dout0), .rx_done(done0),
    .rx_busy(busy0), .parity_err(pe0), .frame_err(fe0));
  uart_rx #(.OVERSAMPLING_RATE(OS), .DATA_WD(8), .PARITY(1)) dut1 (
    .clk(clk), .rst(rst), .tick(tick), .rx(rx1), .dout(dout1), .rx_done(done1),
    .rx_busy(busy1), .parity_err(pe1), .frame_err(fe1));
  uart_rx #(.OVERSAMPLING_RATE(OS), .DATA_WD(8), .PARITY(2)) dut2 (
    .clk(clk), .rst(rst), .tick(tick), .rx(rx2), .dout(dout2), .rx_done(done2),
    .rx_busy(busy2), .parity_err(pe2), .frame_err(fe2));

  always @(negedge clk) begin
    if (done0 === 1'b1) q0.push_back({dout0, pe0, fe0});
    if (done1 === 1'b1) q1.push_back({dout1, pe1, fe1});
    if (done2 === 1'b1) q2.push_back({dout2, pe2, fe2});
  end

  // Reference: parity error means the received parity bit disagrees with
  // even parity (mode 1) or odd parity (mode 2) over the data ones-count.
  function automatic logic model_perr(input int which, input logic [7:0] data, input logic pbit);
    int ones;
    ones = $countones(data);
    if (which == 0) return 1'b0;
    if (which == 1) return pbit != ones[0];
    return pbit == ones[0];
  endfunction

  function automatic int qsize(input int which);
    if (which == 0) return q0.size();
    if (which == 1) return q1.size();
    return q2.size();
  endfunction

  function automatic rec_t pop_rec(input int which);
    rec_t r;
    r = 'x;
    if (which == 0 && q0.size() > 0) r = q0.pop_front();
    if (which == 1 && q1.size() > 0) r = q1.pop_front();
    if (which == 2 && q2.size() > 0) r = q2.pop_front();
    return r;
  endfunction

  task automatic drive_bit(input int which, input logic b);
    case (which)
      0:       rx0 = b;
      1:       rx1 = b;
      default: rx2 = b;
    endcase
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic send_frame(input int which, input logic [7:0] data, input logic pbit, input logic stop);
    drive_bit(which, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(which, data[i]);
    if (which != 0) drive_bit(which, pbit);
    drive_bit(which, stop);
  endtask

  task automatic idle(input int n_bits);
    rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
    repeat (n_bits * BIT_CLK) @(negedge clk);
  endtask

  task automatic test_reset;
    n_checks++; if (dout0 !== 8'h00) $display("FAIL reset_dout: got %h expected 00", dout0); else n_pass++;
    n_checks++; if (done0 !== 1'b0) $display("FAIL reset_done: got %b expected 0", done0); else n_pass++;
    n_checks++; if (busy0 !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy0); else n_pass++;
    n_checks++; if ({pe0, fe0, pe1, fe1} !== 4'b0) $display("FAIL reset_errs: got %b expected 0000", {pe0, fe0, pe1, fe1}); else n_pass++;
    idle(2);
  endtask

  task automatic test_basic;
    rec_t r;
    send_frame(0, 8'hA5, 1'b0, 1'b1);
    idle(2);
    n_checks++; if (q0.size() !== 1) $display("FAIL basic_count: got %0d expected 1", q0.size()); else n_pass++;
    r = pop_rec(0);
    n_checks++; if (r.d !== 8'hA5) $display("FAIL basic_dout: got %h expected a5", r.d); else n_pass++;
    n_checks++; if ({r.pe, r.fe} !== 2'b00) $display("FAIL basic_errs: got %b expected 00", {r.pe, r.fe}); else n_pass++;
    n_checks++; if (busy0 !== 1'b0) $display("FAIL basic_busy: got %b expected 0", busy0); else n_pass++;
    n_checks++; if (dout0 !== 8'hA5) $display("FAIL basic_hold: got %h expected a5", dout0); else n_pass++;
  endtask

  task automatic test_false_start;
    logic saw_busy;
    saw_busy = 1'b0;
    rx0 = 1'b0;
    repeat (4 * TDIV) begin @(negedge clk); saw_busy |= busy0; end
    rx0 = 1'b1;
    repeat (2 * BIT_CLK) begin @(negedge clk); saw_busy |= busy0; end
    n_checks++; if (saw_busy !== 1'b1) $display("FAIL false_busy_pulse: got %b expected 1", saw_busy); else n_pass++;
    n_checks++; if (busy0 !== 1'b0) $display("FAIL false_busy_clear: got %b expected 0", busy0); else n_pass++;
    n_checks++; if (q0.size() !== 0) $display("FAIL false_no_done: got %0d expected 0", q0.size()); else n_pass++;
    n_checks++; if (dout0 !== 8'hA5) $display("FAIL false_dout: got %h expected a5", dout0); else n_pass++;
  endtask

  task automatic test_parity;
    rec_t r;
    send_frame(1, 8'h3C, 1'b0, 1'b1); idle(2);
    r = pop_rec(1);
    n_checks++; if (r.pe !== 1'b0) $display("FAIL par_even_ok: got %b expected 0", r.pe); else n_pass++;
    send_frame(1, 8'h3C, 1'b1, 1'b1); idle(2);
    r = pop_rec(1);
    n_checks++; if (r.pe !== 1'b1) $display("FAIL par_even_bad: got %b expected 1", r.pe); else n_pass++;
    n_checks++; if (r.d !== 8'h3C) $display("FAIL par_dout: got %h expected 3c", r.d); else n_pass++;
    send_frame(2, 8'h3C, 1'b1, 1'b1); idle(2);
    r = pop_rec(2);
    n_checks++; if (r.pe !== 1'b0) $display("FAIL par_odd_ok: got %b expected 0", r.pe); else n_pass++;
    send_frame(2, 8'h3C, 1'b0, 1'b1); idle(2);
    r = pop_rec(2);
    n_checks++; if (r.pe !== 1'b1) $display("FAIL par_odd_bad: got %b expected 1", r.pe); else n_pass++;
  endtask

  task automatic test_break;
    rec_t r;
    send_frame(0, 8'h55, 1'b0, 1'b0);
    rx0 = 1'b0;
    repeat (30 * BIT_CLK) @(negedge clk);
    n_checks++; if (q0.size() !== 1) $display("FAIL break_count: got %0d expected 1", q0.size()); else n_pass++;
    r = pop_rec(0);
    n_checks++; if (r.d !== 8'h55) $display("FAIL break_dout: got %h expected 55", r.d); else n_pass++;
    n_checks++; if ({r.pe, r.fe} !== 2'b01) $display("FAIL break_errs: got %b expected 01", {r.pe, r.fe}); else n_pass++;
    n_checks++; if (busy0 !== 1'b0) $display("FAIL break_busy: got %b expected 0", busy0); else n_pass++;
    idle(2);
    send_frame(0, 8'h5A, 1'b0, 1'b1); idle(2);
    r = pop_rec(0);
    n_checks++; if ({r.d, r.fe} !== {8'h5A, 1'b0}) $display("FAIL break_recover: got %h/%b expected 5a/0", r.d, r.fe); else n_pass++;
  endtask

  task automatic test_back_to_back;
    rec_t r;
    send_frame(0, 8'h01, 1'b0, 1'b1);
    send_frame(0, 8'hFE, 1'b0, 1'b1);
    idle(2);
    n_checks++; if (q0.size() !== 2) $display("FAIL b2b_count: got %0d expected 2", q0.size()); else n_pass++;
    r = pop_rec(0);
    n_checks++; if (r.d !== 8'h01) $display("FAIL b2b_first: got %h expected 01", r.d); else n_pass++;
    r = pop_rec(0);
    n_checks++; if (r.d !== 8'hFE) $display("FAIL b2b_second: got %h expected fe", r.d); else n_pass++;
  endtask

  task automatic test_reset_mid;
    rec_t r;
    logic [7:0] data;
    data = 8'h81;
    drive_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, data[i]);
    rx0 = data[4];
    repeat (BIT_CLK / 2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (dout0 !== 8'h00) $display("FAIL rstmid_dout: got %h expected 00", dout0); else n_pass++;
    n_checks++; if ({done0, busy0, pe0, fe0} !== 4'b0) $display("FAIL rstmid_flags: got %b expected 0000", {done0, busy0, pe0, fe0}); else n_pass++;
    rst = 1'b0;
    idle(2);
    n_checks++; if (q0.size() !== 0) $display("FAIL rstmid_no_done: got %0d expected 0", q0.size()); else n_pass++;
    send_frame(0, 8'h81, 1'b0, 1'b1); idle(2);
    r = pop_rec(0);
    n_checks++; if ({r.d, r.pe, r.fe} !== {8'h81, 2'b00}) $display("FAIL rstmid_next: got %h/%b%b expected 81/00", r.d, r.pe, r.fe); else n_pass++;
  endtask

  task automatic test_random;
    rec_t r;
    int which;
    logic [7:0] data;
    logic pbit, stop;
    for (int k = 0; k < 10; k++) begin
      which = $urandom_range(0, 2);
      data  = 8'($urandom);
      pbit  = 1'($urandom_range(0, 1));
      stop  = ($urandom_range(0, 3) != 0);
      send_frame(which, data, pbit, stop);
      idle(2);
      n_checks++; if (qsize(which) !== 1) $display("FAIL rand_count[%0d]: got %0d expected 1", which, qsize(which)); else n_pass++;
      r = pop_rec(which);
      n_checks++;
      if ({r.d, r.pe, r.fe} !== {data, model_perr(which, data, pbit), ~stop})
        $display("FAIL rand_frame[%0d]: got %h/%b%b expected %h/%b%b", which, r.d, r.pe, r.fe,
                 data, model_perr(which, data, pbit), ~stop);
      else n_pass++;
    end
  endtask

  initial begin
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset;
    test_basic;
    test_false_start;
    test_parity;
    test_break;
    test_back_to_back;
    test_random;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
